// File: rtl/frontend_rw_arbiter_pkg.sv
// Shared types for the frontend read/write arbiter: request address and FSM state.
`include "define.sv"

package frontend_rw_arbiter_pkg;

  localparam int ADDR_W_DEF = `BANK_ADDR_BITS + `ROW_ADDR_BITS + `COL_ADDR_BITS;
  localparam int N_PEND     = 4;

  // {bank, row, col}
  typedef logic [ADDR_W_DEF-1:0] addr_t;

  typedef enum logic {
    READ_MODE   = 1'b0,
    WRITE_DRAIN = 1'b1
  } arb_state_t;

endpackage

// File: rtl/define.sv
// Address field widths and arbitration watermark defaults for the frontend arbiter.
`ifndef FRONTEND_RW_ARBITER_DEFINE_SV
`define FRONTEND_RW_ARBITER_DEFINE_SV

`define BANK_ADDR_BITS 2
`define ROW_ADDR_BITS  8
`define COL_ADDR_BITS  6

`define HIGH_WM_DEF    3
`define LOW_WM_DEF     1
`define STARVE_MAX_DEF 8

`endif

// File: rtl/raw_hazard_cmp.sv
// Read-after-write hazard detect: head read address against every queued write address.
module raw_hazard_cmp
  import frontend_rw_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                           rd_valid,
  input  logic [ADDR_W-1:0]              rd_addr,
  input  logic [N_PEND-1:0][ADDR_W-1:0]  pend_addr,
  input  logic [N_PEND-1:0]              pend_vld,
  output logic                           hazard
);

  logic [N_PEND-1:0] match;

  // Per-slot compare, masked by slot validity so an empty queue never flags.
  always_comb begin
    match = '0;
    for (int k = 0; k < N_PEND; k++) begin
      match[k] = pend_vld[k] && (pend_addr[k] == rd_addr);
    end
  end

  assign hazard = rd_valid && (|match);

endmodule

// File: rtl/frontend_rw_arbiter.sv
// Frontend read/write arbiter: picks one queue head per cycle and presents it as a
// command to the backend controller. Reads are favoured; writes drain on watermark,
// read-after-write hazard or read starvation of a waiting write.
//
// state       | meaning
// READ_MODE   | reads preferred; writes fill cycles with no eligible read
// WRITE_DRAIN | only writes issued until occupancy, hazard and starvation clear
`include "define.sv"

module frontend_rw_arbiter
  import frontend_rw_arbiter_pkg::*;
#(
  parameter int ADDR_W     = `BANK_ADDR_BITS + `ROW_ADDR_BITS + `COL_ADDR_BITS,
  parameter int HIGH_WM    = `HIGH_WM_DEF,
  parameter int LOW_WM     = `LOW_WM_DEF,
  parameter int STARVE_MAX = `STARVE_MAX_DEF
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_rd_valid,
  input  logic [ADDR_W-1:0]             i_rd_addr,
  output logic                          o_rd_pop,
  input  logic                          i_wr_valid,
  input  logic [ADDR_W-1:0]             i_wr_addr,
  input  logic [2:0]                    i_wr_count,
  input  logic [N_PEND-1:0][ADDR_W-1:0] i_wr_pend_addr,
  input  logic [N_PEND-1:0]             i_wr_pend_vld,
  output logic                          o_wr_pop,
  input  logic                          i_backend_controller_ready,
  output logic                          o_cmd_valid,
  output logic                          o_cmd_op,
  output logic [ADDR_W-1:0]             o_cmd_addr,
  output logic                          o_drain
);

  arb_state_t state_q;
  logic [3:0] starve_q;
  logic [3:0] starve_d;
  logic [3:0] starve_after;
  logic [2:0] wr_count_after;
  logic       hazard;
  logic       slot_free;
  logic       force_drain;
  logic       drain_now;
  logic       rd_sel;
  logic       wr_sel;
  logic       wr_left;
  logic       leave_drain;

  raw_hazard_cmp #(
    .ADDR_W (ADDR_W)
  ) u_raw_hazard_cmp (
    .rd_valid  (i_rd_valid),
    .rd_addr   (i_rd_addr),
    .pend_addr (i_wr_pend_addr),
    .pend_vld  (i_wr_pend_vld),
    .hazard    (hazard)
  );

  // Queue selection, pop strobes and drain exit decision for the current cycle.
  always_comb begin
    slot_free   = !o_cmd_valid || i_backend_controller_ready;
    force_drain = (i_wr_count >= 3'(HIGH_WM)) || hazard || (starve_q == 4'(STARVE_MAX));
    // A forced entry already applies drain rules in the transition cycle.
    drain_now   = (state_q == WRITE_DRAIN) || force_drain;

    rd_sel = 1'b0;
    wr_sel = 1'b0;
    if (drain_now) begin
      wr_sel = i_wr_valid;
    end else begin
      rd_sel = i_rd_valid && !hazard;
      wr_sel = !rd_sel && i_wr_valid;
    end

    o_rd_pop = !i_rst && slot_free && rd_sel;
    o_wr_pop = !i_rst && slot_free && wr_sel;
    o_drain  = !i_rst && drain_now;

    // Exit is judged on the queue as it will look after this cycle's pop.
    wr_count_after = i_wr_count - {2'b00, o_wr_pop};
    wr_left        = i_wr_valid && (wr_count_after != 3'd0);
    starve_after   = o_wr_pop ? 4'd0 : starve_q;
    leave_drain    = !wr_left ||
                     ((wr_count_after <= 3'(LOW_WM)) && !hazard &&
                      (starve_after < 4'(STARVE_MAX)));

    starve_d = starve_q;
    if (o_wr_pop) begin
      starve_d = 4'd0;
    end else if (o_rd_pop && i_wr_valid && (starve_q != 4'(STARVE_MAX))) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // FSM state, starvation count and the registered command slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= READ_MODE;
      starve_q    <= 4'd0;
      o_cmd_valid <= 1'b0;
      o_cmd_op    <= 1'b0;
      o_cmd_addr  <= '0;
    end else begin
      state_q  <= (drain_now && !leave_drain) ? WRITE_DRAIN : READ_MODE;
      starve_q <= starve_d;
      if (o_rd_pop || o_wr_pop) begin
        o_cmd_valid <= 1'b1;
        o_cmd_op    <= o_wr_pop;
        o_cmd_addr  <= o_wr_pop ? i_wr_addr : i_rd_addr;
      end else if (i_backend_controller_ready) begin
        o_cmd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/frontend_rw_arbiter.md
FRONTEND_RW_ARBITER -- requirements
Module: frontend_rw_arbiter

Interface
REQ-001 Parameter ADDR_W, default `BANK_ADDR_BITS+`ROW_ADDR_BITS+`COL_ADDR_BITS, request address width {bank,row,col}.
REQ-002 Parameter HIGH_WM, default 3, write-queue occupancy that forces write drain.
REQ-003 Parameter LOW_WM, default 1, write-queue occupancy that ends write drain.
REQ-004 Parameter STARVE_MAX, default 8, number of reads issued past a waiting write before a forced drain.
REQ-005 i_clk  input  1  sole clock, rising edge.
REQ-006 i_rst  input  1  reset, synchronous, active-high.
REQ-007 i_rd_valid  input  1  read request queue non-empty.
REQ-008 i_rd_addr  input  ADDR_W  head read address.
REQ-009 o_rd_pop  output  1  pop read queue head.
REQ-010 i_wr_valid  input  1  write address queue non-empty.
REQ-011 i_wr_addr  input  ADDR_W  head write address.
REQ-012 i_wr_count  input  3  write queue occupancy, 0..4.
REQ-013 i_wr_pend_addr  input  4xADDR_W  all queued write addresses.
REQ-014 i_wr_pend_vld  input  4  valid mask for i_wr_pend_addr.
REQ-015 o_wr_pop  output  1  pop write queue head (address and data together).
REQ-016 i_backend_controller_ready  input  1  backend accepts command.
REQ-017 o_cmd_valid  output  1  command valid.
REQ-018 o_cmd_op  output  1  1 = write, 0 = read.
REQ-019 o_cmd_addr  output  ADDR_W  command address.
REQ-020 o_drain  output  1  high in WRITE_DRAIN.

Function
REQ-021 Output slot is free when !o_cmd_valid or i_backend_controller_ready.
REQ-022 At most one pop per cycle; pops occur only when slot is free; pop and command register load occur in the same cycle, so o_cmd_valid follows the pop by one cycle.
REQ-023 o_cmd_valid/op/addr hold stable while o_cmd_valid && !i_backend_controller_ready.
REQ-024 o_cmd_valid clears after acceptance when no new pop occurs in the accepting cycle.
REQ-025 Hazard = i_rd_valid && i_rd_addr equals any i_wr_pend_addr[k] with i_wr_pend_vld[k].
REQ-026 FSM states READ_MODE, WRITE_DRAIN only.
REQ-027 READ_MODE: issue read if i_rd_valid && !hazard; else issue write if i_wr_valid; else idle.
REQ-028 READ_MODE -> WRITE_DRAIN when i_wr_count >= HIGH_WM, or hazard, or starve counter == STARVE_MAX; the selection in the transition cycle already uses WRITE_DRAIN rules.
REQ-029 WRITE_DRAIN: issue write if i_wr_valid; never issue read.
REQ-030 WRITE_DRAIN -> READ_MODE when !i_wr_valid, or (i_wr_count <= LOW_WM && !hazard && starve counter < STARVE_MAX), evaluated after the current cycle's pop.
REQ-031 Starve counter: 4 bits; +1 on each read issue while i_wr_valid; saturates at STARVE_MAX; clears on any write issue.
REQ-032 Simultaneous read and write eligibility in READ_MODE without forced drain: read wins.
REQ-033 Hazard with empty write queue is impossible by construction; if i_wr_pend_vld == 0 hazard is 0.

Reset
REQ-034 i_rst high at a clock edge: state READ_MODE, o_cmd_valid 0, o_cmd_op 0, o_cmd_addr 0, starve counter 0, o_drain 0; o_rd_pop and o_wr_pop 0 throughout reset.
REQ-035 Reset mid-handshake drops the held command; no pop is issued in the reset cycle.

Structure
REQ-036 ADDR_W-derived address typedef and the fsm state enum live in usertype package; watermark defaults in define.sv.
REQ-037 One sub-module, raw_hazard_cmp: combinational 4-way address comparator producing the hazard bit.

Verification
REQ-038 Reads only, ready always 1: 4 reads -> o_rd_pop 4 consecutive cycles, o_cmd_valid op=0 one cycle later each, back-to-back.
REQ-039 i_wr_count=3 with reads pending -> o_drain=1 same cycle, writes issued until count=1, then reads resume.
REQ-040 Read addr 0x0123 matches pend_addr[2] valid -> no read pop; writes drain until mask clears, then read 0x0123 issued.
REQ-041 Continuous reads, 1 write waiting, ready=1 -> exactly 8 reads issued, then write issued, counter 0.
REQ-042 Ready low 5 cycles with valid command -> outputs stable, no pops; ready high -> accepted, next pop same cycle.
REQ-043 i_rst asserted while o_cmd_valid=1 and drain active -> next cycle all outputs 0, READ_MODE.
